mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 82 ++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mem_arbiter : time-slot arbiter sharing one sync byte RAM between CPU/video
// Rev 1.0
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 20
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              ce,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_out,
  input  logic              cpu_we,
  output logic              cpu_ce,
  output logic [7:0]        cpu_in,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_address,
  output logic              vid_ack,
  output logic [7:0]        vid_data,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_out,
  output logic              mem_we,
  input  logic [7:0]        mem_in
);

  typedef enum logic {
    SLOT_CPU = 1'b0,
    SLOT_VID = 1'b1
  } slot_t;

  slot_t       r_slot_vid;
  slot_t       w_slot_nxt;
  logic        r_last_cpu;
  logic [7:0]  r_cpu_hold;
  logic        r_vid_ack;
  logic [7:0]  r_vid_hold;
  logic        w_cpu_slot;

  // A VID slot is never followed by another, so one request cannot be granted twice
  always_comb begin
    w_slot_nxt = SLOT_CPU;
    if (vid_req && (r_slot_vid == SLOT_CPU)) begin
      w_slot_nxt = SLOT_VID;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_vid <= SLOT_CPU;
      r_last_cpu <= 1'b0;
      r_cpu_hold <= 8'h00;
      r_vid_ack  <= 1'b0;
      r_vid_hold <= 8'h00;
    end else begin
      r_slot_vid <= w_slot_nxt;
      r_last_cpu <= ce && (r_slot_vid == SLOT_CPU);
      r_vid_ack  <= (r_slot_vid == SLOT_VID);
      if (r_last_cpu) begin
        r_cpu_hold <= mem_in;
      end
      if (r_vid_ack) begin
        r_vid_hold <= mem_in;
      end
    end
  end

  // Gating with reset_n keeps the CPU frozen and writes off while reset is held
  assign w_cpu_slot  = reset_n && (r_slot_vid == SLOT_CPU);

  assign mem_address = (r_slot_vid == SLOT_VID) ? vid_address : cpu_address;
  assign mem_out     = cpu_out;
  assign mem_we      = cpu_we && ce && w_cpu_slot;
  assign cpu_ce      = ce && w_cpu_slot;

  // RAM output is already registered; the hold registers cover the cycles it is not ours
  assign cpu_in      = r_last_cpu ? mem_in : r_cpu_hold;
  assign vid_ack     = r_vid_ack;
  assign vid_data    = r_vid_ack ? mem_in : r_vid_hold;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mem_arbiter : scoreboard bench for mem_arbiter with transaction-level model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int ADDR_W = 20;
  localparam logic [ADDR_W-1:0] VADDR = 20'hB8000;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              ce;
  logic [ADDR_W-1:0] cpu_address;
  logic [7:0]        cpu_out;
  logic              cpu_we;
  logic              cpu_ce;
  logic [7:0]        cpu_in;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_address;
  logic              vid_ack;
  logic [7:0]        vid_data;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_out;
  logic              mem_we;
  logic [7:0]        mem_in;

  always #5 clock = ~clock;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset_n(reset_n), .ce(ce),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we),
    .cpu_ce(cpu_ce), .cpu_in(cpu_in),
    .vid_req(vid_req), .vid_address(vid_address),
    .vid_ack(vid_ack), .vid_data(vid_data),
    .mem_address(mem_address), .mem_out(mem_out), .mem_we(mem_we), .mem_in(mem_in)
  );

  // Physical RAM seen by the DUT (read-first, 1-cycle latency)
  bit [7:0] ram    [0:(1<<ADDR_W)-1];
  bit [7:0] shadow [0:(1<<ADDR_W)-1];

  always @(posedge clock) begin
    if (mem_we) ram[mem_address] <= mem_out;
    mem_in <= ram[mem_address];
  end

  typedef struct {
    logic              cpu_ce;
    logic              mem_we;
    logic              vid_ack;
    logic [7:0]        cpu_in;
    logic [ADDR_W-1:0] addr;
  } exp_t;

  exp_t       cyc_q[$];
  logic [7:0] vid_q[$];
  exp_t       mon_e;
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         run_mon  = 1'b0;

  // Reference model state: who owns the current slot, whether the previous slot was video,
  // and the read result of the CPU's most recent enabled access.
  bit         m_slot_vid;
  bit         m_prev_vid;
  logic [7:0] m_cpu_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n && run_mon && cyc_q.size() > 0) begin
      mon_e = cyc_q.pop_front();
      chk("cpu_ce", 32'(cpu_ce), 32'(mon_e.cpu_ce));
      chk("mem_we", 32'(mem_we), 32'(mon_e.mem_we));
      chk("mem_address", 32'(mem_address), 32'(mon_e.addr));
      chk("vid_ack", 32'(vid_ack), 32'(mon_e.vid_ack));
      chk("cpu_in", 32'(cpu_in), 32'(mon_e.cpu_in));
      if (vid_ack) begin
        if (vid_q.size() == 0) chk("vid_ack_unexpected", 32'd1, 32'd0);
        else chk("vid_data", 32'(vid_data), 32'(vid_q.pop_front()));
      end
    end
  end

  task automatic model_reset();
    m_slot_vid = 1'b0;
    m_prev_vid = 1'b0;
    m_cpu_data = 8'h00;
  endtask

  task automatic cyc(input bit i_ce, input logic [ADDR_W-1:0] a, input bit we,
                     input logic [7:0] d, input bit rq, input logic [ADDR_W-1:0] va);
    exp_t ex;
    ce = i_ce; cpu_address = a; cpu_we = we; cpu_out = d;
    vid_req = rq; vid_address = va;
    ex.cpu_ce  = i_ce && !m_slot_vid;
    ex.mem_we  = we && i_ce && !m_slot_vid;
    ex.vid_ack = m_prev_vid;
    ex.cpu_in  = m_cpu_data;
    ex.addr    = m_slot_vid ? va : a;
    cyc_q.push_back(ex);
    if (m_slot_vid) begin
      vid_q.push_back(shadow[va]);
    end else if (i_ce) begin
      m_cpu_data = shadow[a];
      if (we) shadow[a] = d;
    end
    m_prev_vid = m_slot_vid;
    m_slot_vid = rq && !m_slot_vid;
    @(posedge clock); #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_caddr();
    case ($urandom_range(0, 3))
      0:       return VADDR + ADDR_W'($urandom_range(0, 3));
      1:       return 20'h00100;
      default: return ADDR_W'($urandom_range(0, 31));
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] rand_vaddr();
    if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, 31));
    return VADDR + ADDR_W'($urandom_range(0, 7));
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cpu_ce"},   32'(cpu_ce),   32'd0);
    chk({tag, "_mem_we"},   32'(mem_we),   32'd0);
    chk({tag, "_vid_ack"},  32'(vid_ack),  32'd0);
    chk({tag, "_cpu_in"},   32'(cpu_in),   32'h00);
    chk({tag, "_vid_data"}, 32'(vid_data), 32'h00);
  endtask

  bit                rq;
  logic [ADDR_W-1:0] rva;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom); shadow[i] = ram[i];
    end
    for (int i = 0; i < 8; i++) begin
      ram[VADDR + ADDR_W'(i)] = 8'($urandom); shadow[VADDR + ADDR_W'(i)] = ram[VADDR + ADDR_W'(i)];
    end
    ram['h10]  = 8'h5A; shadow['h10]  = 8'h5A;
    ram[VADDR] = 8'h41; shadow[VADDR] = 8'h41;
    ram['h20]  = 8'h33; shadow['h20]  = 8'h33;
    ram['h100] = 8'h00; shadow['h100] = 8'h00;

    reset_n = 1'b0; ce = 1'b1; cpu_we = 1'b1; cpu_address = '0; cpu_out = 8'hFF;
    vid_req = 1'b0; vid_address = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    cpu_we = 1'b0;
    reset_n = 1'b1;
    model_reset();
    run_mon = 1'b1;

    // CPU read with no video traffic
    cyc(1, 20'h00010, 0, 8'h00, 0, '0);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);

    // Single video read
    cyc(1, 20'h00000, 0, 8'h00, 1, VADDR);
    cyc(1, 20'h00000, 0, 8'h00, 1, VADDR);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);

    // CPU read immediately followed by a video slot
    cyc(1, 20'h00020, 0, 8'h00, 1, VADDR);
    cyc(1, 20'h00020, 0, 8'h00, 1, VADDR);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);

    // Write and video request together
    cyc(1, 20'h00100, 1, 8'h77, 1, VADDR);
    cyc(1, 20'h00100, 1, 8'h77, 1, VADDR);
    cyc(1, 20'h00100, 0, 8'h00, 0, '0);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);
    chk("ram_write_0x100", 32'(ram['h100]), 32'h77);

    // Video request held continuously
    for (int i = 0; i < 10; i++) cyc(1, rand_caddr(), 0, 8'h00, 1, VADDR);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);

    // ce=0 must not block video
    cyc(0, 20'h00005, 1, 8'hEE, 1, VADDR + 20'd1);
    cyc(0, 20'h00005, 1, 8'hEE, 1, VADDR + 20'd1);
    cyc(0, 20'h00005, 0, 8'h00, 0, '0);
    cyc(1, 20'h00005, 0, 8'h00, 0, '0);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);

    // Reset pulse between a video slot and its ack
    cyc(1, 20'h00010, 0, 8'h00, 1, VADDR + 20'd4);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clock); #1;
    check_reset_outputs("ackdrop");
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
    cyc(1, 20'h00000, 0, 8'h00, 1, VADDR + 20'd4);
    cyc(1, 20'h00000, 0, 8'h00, 1, VADDR + 20'd4);
    cyc(1, 20'h00000, 0, 8'h00, 0, '0);

    // Randomized traffic
    rq = 1'b0; rva = '0;
    for (int i = 0; i < 500; i++) begin
      if (rq && m_prev_vid) begin
        rq  = ($urandom_range(0, 1) == 1);
        rva = rand_vaddr();
      end else if (!rq) begin
        rq  = ($urandom_range(0, 2) == 0);
        rva = rand_vaddr();
      end
      cyc(($urandom_range(0, 4) != 0), rand_caddr(), ($urandom_range(0, 2) == 0),
          8'($urandom), rq, rva);
    end
    for (int i = 0; i < 3; i++) cyc(1, 20'h00000, 0, 8'h00, 0, '0);

    @(negedge clock); #1;
    chk("vid_q_drained", 32'(vid_q.size()), 32'd0);
    chk("cyc_q_drained", 32'(cyc_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
